// File: rtl/seq_mult_pkg.sv
// Shared FSM encoding and sizing helper for the sequential PE multiplier.
package seq_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_t;

  // Bits needed to hold values 0..n-1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_mult_pe_if.sv
// Operand/product handshake bundle between PE operand registers and the accumulate stage.
interface seq_mult_pe_if #(parameter int BITWIDTH = 8);

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic                    signed_mode;
  logic [BITWIDTH-1:0]     din1;
  logic [BITWIDTH-1:0]     din2;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*BITWIDTH-1:0]   dout;

  modport master (
    output flush, in_valid, signed_mode, din1, din2, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  flush, in_valid, signed_mode, din1, din2, out_ready,
    output in_ready, out_valid, dout
  );

endinterface

// File: rtl/seq_mult_pe_abs_neg.sv
// Conditional two's-complement negate: dout = neg ? -din : din, combinational.
module pe_abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + 1'b1) : din;

endmodule

// File: rtl/seq_mult_pe.sv
// Shift-add multiplier, one step per cycle; out_valid BITWIDTH cycles after accept, holds in DONE until out_ready.
// Optional running accumulator on each product handshake: define SEQ_MULT_ACC_EN.
module seq_mult_pe
  import seq_mult_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int ACC_GUARD = 8
) (
  input  logic                              fast_clk,
  input  logic                              rst,
`ifdef SEQ_MULT_ACC_EN
  input  logic                              acc_clr,
  output logic [2*BITWIDTH+ACC_GUARD-1:0]   acc_out,
`endif
  seq_mult_pe_if.slave                      bus
);

  localparam int PW = 2 * BITWIDTH;
  localparam int CW = clog2(BITWIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(BITWIDTH - 1);

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [BITWIDTH-1:0] cand, lier, mag1, mag2, addend;
  logic [PW-1:0]       out_buf, prod;
  logic [PW:0]         tmp;
  logic                neg, accept;

  pe_abs_neg #(.W(BITWIDTH)) u_abs1 (
    .din (bus.din1),
    .neg (bus.signed_mode & bus.din1[BITWIDTH-1]),
    .dout(mag1)
  );

  pe_abs_neg #(.W(BITWIDTH)) u_abs2 (
    .din (bus.din2),
    .neg (bus.signed_mode & bus.din2[BITWIDTH-1]),
    .dout(mag2)
  );

  pe_abs_neg #(.W(PW)) u_sign_fix (
    .din (out_buf),
    .neg (neg),
    .dout(prod)
  );

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (bus.in_valid) begin
        accept   = 1'b1;
        state_nx = BUSY;
      end
      BUSY: if (cnt == LAST_STEP) state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) begin
      state_nx = IDLE;
      accept   = 1'b0;
    end
  end

  // Partial product lands in the upper half; the extra top bit keeps the carry before the shift.
  assign addend = lier[0] ? cand : '0;
  assign tmp    = {1'b0, out_buf} + {1'b0, addend, {BITWIDTH{1'b0}}};

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst) begin
      cand    <= '0;
      lier    <= '0;
      out_buf <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else if (bus.flush) begin
      out_buf <= '0;
      cnt     <= '0;
    end else if (accept) begin
      cand    <= mag1;
      lier    <= mag2;
      out_buf <= '0;
      cnt     <= '0;
      neg     <= bus.signed_mode & (bus.din1[BITWIDTH-1] ^ bus.din2[BITWIDTH-1]);
    end else if (state == BUSY) begin
      out_buf <= tmp[PW:1];
      lier    <= lier >> 1;
      cnt     <= cnt + 1'b1;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.dout      = bus.out_valid ? prod : '0;

`ifdef SEQ_MULT_ACC_EN
  localparam int AW = PW + ACC_GUARD;

  logic          sgn;
  logic          hs;
  logic [AW-1:0] prod_ext;

  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst)        sgn <= 1'b0;
    else if (accept) sgn <= bus.signed_mode;
  end

  assign hs       = bus.out_valid & bus.out_ready;
  assign prod_ext = sgn ? {{ACC_GUARD{bus.dout[PW-1]}}, bus.dout}
                        : {{ACC_GUARD{1'b0}}, bus.dout};

  // A clear coinciding with a handshake restarts the sum at that product.
  always_ff @(posedge fast_clk or negedge rst) begin
    if (!rst)                acc_out <= '0;
    else if (acc_clr && hs)  acc_out <= prod_ext;
    else if (acc_clr)        acc_out <= '0;
    else if (hs)             acc_out <= acc_out + prod_ext;
  end
`else
  localparam int acc_guard_unused = ACC_GUARD;
`endif

endmodule

// File: tb/tb_seq_mult_pe.sv
// Scoreboard bench for seq_mult_pe (BITWIDTH=8); accumulator checks only when SEQ_MULT_ACC_EN is defined.
module tb_seq_mult_pe;

  logic fast_clk = 1'b0;
  logic rst      = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic [15:0] exp_q[$];

  always #5 fast_clk = ~fast_clk;
  always @(posedge fast_clk) cyc <= cyc + 1;

  seq_mult_pe_if #(.BITWIDTH(8)) bus();

`ifdef SEQ_MULT_ACC_EN
  logic        acc_clr = 1'b0;
  logic [23:0] acc_out;
`endif

  seq_mult_pe #(.BITWIDTH(8), .ACC_GUARD(8)) dut (
    .fast_clk(fast_clk),
    .rst     (rst),
`ifdef SEQ_MULT_ACC_EN
    .acc_clr (acc_clr),
    .acc_out (acc_out),
`endif
    .bus     (bus)
  );

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sm);
    logic signed [15:0] sa, sb;
    if (sm) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return 16'(sa * sb);
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  // Drive one operand pair at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input bit push, output int acc_cyc);
    bus.din1 = a; bus.din2 = b; bus.signed_mode = sm; bus.in_valid = 1'b1;
    if (push) exp_q.push_back(model(a, b, sm));
    acc_cyc = cyc;
    @(negedge fast_clk);
    bus.in_valid    = 1'b0;
    bus.din1        = 8'($urandom);
    bus.din2        = 8'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(negedge fast_clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge fast_clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge fast_clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.dout !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h want=0000", bus.dout); end
    rst = 1'b1;
    @(negedge fast_clk);
  endtask

  task automatic run_mode(input string name, input logic [7:0] a, input logic [7:0] b, input logic sm);
    int t, lat;
    logic [15:0] e;
    issue(a, b, sm, 1'b1, t);
    wait_valid(lat);
    e = exp_q.pop_front();
    checks++; if (lat !== 8) begin failures++; $display("FAIL %s_latency got=%0d want=8", name, lat); end
    checks++; if (bus.dout !== e) begin failures++; $display("FAIL %s_dout a=%h b=%h got=%h want=%h", name, a, b, bus.dout, e); end
    consume();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL %s_return_idle in_ready=%b out_valid=%b want 1/0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_unsigned();
    run_mode("u_ff_ff", 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) run_mode("u_rand", 8'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic test_signed();
    run_mode("s_m5_7", 8'hFB, 8'h07, 1'b1);
    run_mode("s_m128_m128", 8'h80, 8'h80, 1'b1);
    run_mode("s_m128_127", 8'h80, 8'h7F, 1'b1);
    for (int i = 0; i < 4; i++) run_mode("s_rand", 8'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic test_backpressure();
    int t, lat;
    logic [15:0] e;
    bit bad;
    issue(8'h21, 8'h13, 1'b0, 1'b1, t);
    wait_valid(lat);
    e = exp_q.pop_front();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.dout !== e || bus.in_ready !== 1'b0) bad = 1'b1;
      @(negedge fast_clk);
    end
    checks++; if (bad || bus.dout !== e) begin failures++; $display("FAIL bp_hold dout=%h want=%h out_valid=%b in_ready=%b", bus.dout, e, bus.out_valid, bus.in_ready); end
    consume();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dout !== 16'h0) begin
      failures++; $display("FAIL bp_release in_ready=%b out_valid=%b dout=%h want 1/0/0000", bus.in_ready, bus.out_valid, bus.dout);
    end
  endtask

  task automatic test_flush();
    int t;
    bit seen;
    issue(8'h12, 8'h34, 1'b0, 1'b0, t);
    repeat (2) @(negedge fast_clk);
    bus.flush = 1'b1;
    @(negedge fast_clk);
    bus.flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid !== 1'b0) seen = 1'b1;
      @(negedge fast_clk);
    end
    checks++; if (seen || bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_discard out_valid_seen=%b in_ready=%b want 0/1", seen, bus.in_ready); end
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.din1 = 8'h09; bus.din2 = 8'h09;
    @(negedge fast_clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    @(negedge fast_clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_blocks_accept in_ready=%b want=1", bus.in_ready); end
    run_mode("flush_next", 8'h03, 8'h04, 1'b0);
  endtask

  task automatic test_rst_mid();
    int t;
    issue(8'h5A, 8'hC3, 1'b0, 1'b0, t);
    repeat (3) @(negedge fast_clk);
    @(posedge fast_clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dout !== 16'h0) begin
      failures++; $display("FAIL rst_mid in_ready=%b out_valid=%b dout=%h want 1/0/0000", bus.in_ready, bus.out_valid, bus.dout);
    end
    @(negedge fast_clk);
    rst = 1'b1;
    @(negedge fast_clk);
    run_mode("rst_zero", 8'h00, 8'hAB, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t0, t1, lat;
    logic [15:0] e;
    bus.out_ready = 1'b1;
    issue(8'($urandom), 8'($urandom), 1'b0, 1'b1, t0);
    for (int i = 0; i < 4; i++) begin
      wait_valid(lat);
      e = exp_q.pop_front();
      checks++; if (lat !== 8 || bus.dout !== e) begin failures++; $display("FAIL b2b_result lat=%0d dout=%h want 8/%h", lat, bus.dout, e); end
      @(negedge fast_clk);
      if (i < 3) begin
        issue(8'($urandom), 8'($urandom), 1'(i[0]), 1'b1, t1);
        checks++; if (t1 - t0 !== 10) begin failures++; $display("FAIL b2b_spacing got=%0d want=10", t1 - t0); end
        t0 = t1;
      end
    end
    bus.out_ready = 1'b0;
  endtask

`ifdef SEQ_MULT_ACC_EN
  task automatic acc_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        input logic clr, input logic [23:0] want);
    int t, lat;
    issue(a, b, sm, 1'b0, t);
    wait_valid(lat);
    acc_clr = clr;
    @(negedge fast_clk);
    acc_clr = 1'b0;
    checks++; if (acc_out !== want) begin failures++; $display("FAIL acc a=%h b=%h got=%h want=%h", a, b, acc_out, want); end
  endtask

  task automatic test_acc();
    acc_clr = 1'b1;
    @(negedge fast_clk);
    acc_clr = 1'b0;
    checks++; if (acc_out !== 24'd0) begin failures++; $display("FAIL acc_clr got=%h want=0", acc_out); end
    bus.out_ready = 1'b1;
    acc_op(8'd3, 8'd4, 1'b0, 1'b0, 24'd12);
    acc_op(8'hFE, 8'd5, 1'b1, 1'b0, 24'd2);
    acc_op(8'd6, 8'd1, 1'b0, 1'b0, 24'd8);
    acc_op(8'd2, 8'd2, 1'b0, 1'b1, 24'd4);
    bus.out_ready = 1'b0;
  endtask
`endif

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.signed_mode = 1'b0;
    bus.din1 = 8'h0; bus.din2 = 8'h0; bus.out_ready = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_flush();
    test_rst_mid();
    test_back_to_back();
`ifdef SEQ_MULT_ACC_EN
    test_acc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
